i2c_target_rx: RTL

Receive-only I2C target (slave) that answers write transactions from master_i2c on the shared i2c_sda/i2c_scl bus.
- Oversamples SCL/SDA on the system clock.
- Detects START/STOP and matches a 7-bit address.
- Shifts in up to NBYTES data bytes MSB-first and ACKs each byte.
- Presents the assembled payload as one wide word with a one-cycle valid strobe at end of frame.

---
 rtl/i2c_target_rx_if.sv | 23 ++
 rtl/i2c_target_rx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/i2c_target_rx_if.sv
// rtl/i2c_target_rx_if.sv - SCL input and payload/status outputs of the receive-only I2C target
interface i2c_target_rx_if #(
    parameter int NBYTES = 13
);
    localparam int BCW = $clog2(NBYTES + 1);

    logic                  i2c_scl;
    logic [8*NBYTES-1:0]   data_out;
    logic [BCW-1:0]        byte_count;
    logic                  data_valid;
    logic                  busy;
    logic                  overflow;

    modport slave (
        input  i2c_scl,
        output data_out, byte_count, data_valid, busy, overflow
    );

    modport master (
        output i2c_scl,
        input  data_out, byte_count, data_valid, busy, overflow
    );
endinterface

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - receive-only I2C target: address match, byte ACK, wide payload commit
module i2c_target_rx #(
    parameter logic [6:0] ADDRESS = 7'b0001101,
    parameter int         NBYTES  = 13
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               i2c_sda,
    i2c_target_rx_if.slave    bus
);
    localparam int BCW = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

    state_t              state;
    logic                scl_s1, scl_s2, scl_d;
    logic                sda_s1, sda_s2, sda_d;
    logic [2:0]          bit_cnt;
    logic [6:0]          shift;
    logic [8*NBYTES-1:0] shadow;
    logic [BCW-1:0]      idx;
    logic                sda_low;

    logic scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] rx_byte;

    // START/STOP need SCL high on both sides of the SDA edge so data changes never alias
    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte  = {shift, sda_s2};

    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            scl_s1         <= 1'b1;
            scl_s2         <= 1'b1;
            scl_d          <= 1'b1;
            sda_s1         <= 1'b1;
            sda_s2         <= 1'b1;
            sda_d          <= 1'b1;
            bit_cnt        <= '0;
            shift          <= '0;
            shadow         <= '0;
            idx            <= '0;
            sda_low        <= 1'b0;
            bus.data_out   <= '0;
            bus.byte_count <= '0;
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            scl_s1         <= bus.i2c_scl;
            scl_s2         <= scl_s1;
            scl_d          <= scl_s2;
            sda_s1         <= i2c_sda;
            sda_s2         <= sda_s1;
            sda_d          <= sda_s2;
            bus.data_valid <= 1'b0;

            if (start_c || stop_c) begin
                // Commit whole bytes only; any partially shifted byte is dropped
                if (bus.busy && idx != '0) begin
                    bus.data_out   <= shadow;
                    bus.byte_count <= idx;
                    bus.data_valid <= 1'b1;
                end
                bus.busy <= 1'b0;
                sda_low  <= 1'b0;
                bit_cnt  <= '0;
                if (start_c) begin
                    state        <= ADDR;
                    shadow       <= '0;
                    idx          <= '0;
                    bus.overflow <= 1'b0;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (rx_byte == {ADDRESS, 1'b0}) begin
                                    state    <= ADDR_ACK;
                                    bus.busy <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // First fall after the 8th bit grabs SDA, the 9th fall lets go
                        if (scl_fall) begin
                            if (!sda_low) begin
                                sda_low <= 1'b1;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (idx == BCW'(NBYTES)) begin
                                    bus.overflow <= 1'b1;
                                    state        <= IGNORE;
                                end else begin
                                    for (int i = 0; i < NBYTES; i++) begin
                                        if (idx == BCW'(i))
                                            shadow[8*(NBYTES-i)-1 -: 8] <= rx_byte;
                                    end
                                    idx   <= idx + 1'b1;
                                    state <= DATA_ACK;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
